// File: rtl/gray_ptr_synchronizer.sv
// Brings a Gray-coded FIFO pointer into the Clk domain through a flop chain and publishes
// its binary value, per-sample advance and change strobe. Define GRAY_PTR_CHECK_EN to add gray_err.
module gray_ptr_synchronizer #(
    parameter int A_WIDTH = 4,
    parameter int STAGES  = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [A_WIDTH:0]   ptr_gray_in,
    input  logic               err_clr,
    output logic [A_WIDTH:0]   ptr_gray_sync,
    output logic [A_WIDTH:0]   ptr_bin_sync,
    output logic [A_WIDTH:0]   ptr_delta,
    output logic               ptr_chg
`ifdef GRAY_PTR_CHECK_EN
    ,
    output logic               gray_err
`endif
);

    localparam int PW = A_WIDTH + 1;
    localparam logic [PW-1:0] ONE = PW'(1);

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_stages_illegal
            $error("gray_ptr_synchronizer: STAGES must be within 2..4");
        end
    endgenerate

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit of x is set (clearing the lowest set bit leaves something).
    function automatic logic multi_bit(input logic [PW-1:0] x);
        return |(x & (x - ONE));
    endfunction

    logic [PW-1:0] sync_q [STAGES];

    logic [PW-1:0] bin_q,   bin_d;
    logic [PW-1:0] delta_q, delta_d;
    logic          chg_q,   chg_d;

    // Synchroniser chain: plain flops, nothing between the input and stage 0 or between stages.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= ptr_gray_in;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign ptr_gray_sync = sync_q[STAGES-1];

    // Binary conversion stage; delta wraps naturally through the truncating subtract.
    always_comb begin
        bin_d   = gray2bin(ptr_gray_sync);
        delta_d = bin_d - bin_q;
        chg_d   = (bin_d != bin_q);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bin_q   <= '0;
            delta_q <= '0;
            chg_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            delta_q <= delta_d;
            chg_q   <= chg_d;
        end
    end

    assign ptr_bin_sync = bin_q;
    assign ptr_delta    = delta_q;
    assign ptr_chg      = chg_q;

`ifdef GRAY_PTR_CHECK_EN
    logic [PW-1:0] prev_q;
    logic          err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (multi_bit(ptr_gray_sync ^ prev_q)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Previous-sample register resets to 0 so the first post-reset sample is checked against 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= ptr_gray_sync;
            err_q  <= err_d;
        end
    end

    assign gray_err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

endmodule
